useq_sequencer: RTL and testbench
=================================

USEQ_SEQUENCER -- requirements
Module: useq_sequencer

Interface
REQ-001 SHALL have parameter UPC_W, default 8, micro-PC width.
REQ-002 SHALL have parameter UINST_W, default 32, micro-instruction width, minimum 4.
REQ-003 SHALL have parameter LOOP_DEPTH, default 3, number of nested hardware loop levels, minimum 1.
REQ-004 SHALL have parameter CNT_W, default 11, loop iteration count width.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port cmd_valid  input  1  command offered.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-009 SHALL have port cmd_upc  input  UPC_W  micro-program start address.
REQ-010 SHALL have port cmd_loops  input  LOOP_DEPTH*CNT_W  iteration count per level; level k is slice [k*CNT_W +: CNT_W].
REQ-011 SHALL have port abort  input  1  terminate the running program.
REQ-012 SHALL have port urom_addr  output  UPC_W  synchronous micro-ROM address, combinational from next-upc.
REQ-013 SHALL have port urom_data  input  UINST_W  ROM word, one-cycle read latency.
REQ-014 SHALL have port ctrl_out  output  UINST_W-3  datapath control field urom_data[UINST_W-1:3], gated to 0 when ctrl_valid is low.
REQ-015 SHALL have port ctrl_valid  output  1  ctrl_out is live this cycle.
REQ-016 SHALL have ports busy (1, state is EXEC), done (1, one-cycle completion pulse), err (1, one-cycle fault pulse), all outputs.

Function
REQ-017 SHALL decode urom_data bits: [0] done, [1] loop_push, [2] loop_end.
REQ-018 SHALL implement states IDLE and EXEC; cmd_ready = (state==IDLE) & ~abort.
REQ-019 On accept: SHALL register cmd_loops, drive urom_addr = cmd_upc, set upc = cmd_upc, and enter EXEC; ctrl_valid SHALL rise the next cycle (latency 1).
REQ-020 In EXEC, ctrl_valid SHALL be 1 every cycle; one micro-instruction retires per cycle with no bubbles, including taken loop branches.
REQ-021 Sequential next-upc SHALL be upc+1; an increment wrapping past 2^UPC_W-1 SHALL raise err and return to IDLE.
REQ-022 loop_push SHALL push {start=upc+1, remaining=count of level sp} and increment sp; count 0 SHALL behave as 1.
REQ-023 loop_end with remaining>1 SHALL decrement remaining and set next-upc = start; with remaining<=1 SHALL pop and take upc+1.
REQ-024 A uinst with loop_push and loop_end both set, a push at sp==LOOP_DEPTH, or loop_end at sp==0 SHALL raise err for one cycle and go to IDLE; ctrl_valid stays 1 for that faulting uinst.
REQ-025 A uinst with done=1 SHALL be output with ctrl_valid=1, then state SHALL be IDLE the next cycle with done=1 for exactly that cycle; loop stack SHALL clear.
REQ-026 done SHALL take priority over loop bits in the same uinst; loop bits SHALL then be ignored.
REQ-027 abort in EXEC SHALL force IDLE next cycle, clear the stack, suppress done and err; the current uinst is still output.
REQ-028 A new command SHALL be accepted in the IDLE cycle that carries the done pulse (back-to-back).
REQ-029 In IDLE, urom_addr SHALL equal cmd_upc.

Reset
REQ-030 On rst: state IDLE, upc 0, sp 0, stack entries 0, ctrl_valid 0, ctrl_out 0, busy 0, done 0, err 0, cmd_ready 1 after release.
REQ-031 rst asserted mid-program SHALL abandon it immediately, with no done and no err pulse.

Structure
REQ-032 Package useq_pkg SHALL hold the uinst bit positions (DONE_BIT, PUSH_BIT, END_BIT, CTRL_LSB) and the state enum.
REQ-033 The loop stack SHALL be a sub-module useq_loop_stack: push, pop, decrement, top outputs, full, empty, parametrised by LOOP_DEPTH, UPC_W and CNT_W.

Verification
REQ-034 Cmd upc=0x10, ROM 0x10..0x13 plain and 0x13 done -> ctrl_valid for 4 cycles starting 1 cycle after accept, done pulse the next cycle, then cmd_ready=1.
REQ-035 Level-0 count 3, push at 0x20, body 0x21-0x22, loop_end at 0x22, done at 0x23 -> upc trace 20,21,22,21,22,21,22,23 with no gap cycles.
REQ-036 Two nested loops with counts 2 and 3 -> inner body executes 6 times, outer 2, then done; LOOP_DEPTH=1 build with the same program -> err on the second push.
REQ-037 abort asserted on the 3rd EXEC cycle -> IDLE next cycle, no done and no err pulse, stack empty, and the next command runs correctly.
REQ-038 loop_end at sp=0 -> single err pulse, then IDLE; separately, done followed by a back-to-back command -> ctrl_valid gap of exactly 1 cycle.
REQ-039 rst pulsed mid-loop -> all outputs at reset values asynchronously, and a fresh command completes normally.

Source files
------------

// File: rtl/useq_pkg.sv
// Shared definitions for the micro-sequencer: micro-instruction field layout,
// FSM state encoding and loop-stack pointer sizing.
package useq_pkg;

  localparam int unsigned DONE_BIT = 0;
  localparam int unsigned PUSH_BIT = 1;
  localparam int unsigned END_BIT  = 2;
  localparam int unsigned CTRL_LSB = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } useq_state_e;

  // Stack pointer counts 0..depth inclusive, so it needs one extra code point.
  function automatic int unsigned sp_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/useq_loop_stack.sv
// Hardware loop stack: each level holds the loop start address and the
// iterations still to run; the top entry is presented combinationally.
module useq_loop_stack
  import useq_pkg::*;
#(
  parameter int unsigned LOOP_DEPTH = 3,
  parameter int unsigned UPC_W      = 8,
  parameter int unsigned CNT_W      = 11,
  localparam int unsigned SP_W      = sp_width(LOOP_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             dec,
  input  logic             clr,
  input  logic [UPC_W-1:0] push_start,
  input  logic [CNT_W-1:0] push_cnt,
  output logic [UPC_W-1:0] top_start,
  output logic [CNT_W-1:0] top_remaining,
  output logic [SP_W-1:0]  sp,
  output logic             full,
  output logic             empty
);

  logic [UPC_W-1:0] start_q [LOOP_DEPTH];
  logic [CNT_W-1:0] rem_q   [LOOP_DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic [SP_W-1:0]  top_idx;

  assign sp      = sp_q;
  assign full    = (sp_q == SP_W'(LOOP_DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = sp_q - SP_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
      for (int unsigned i = 0; i < LOOP_DEPTH; i++) begin
        start_q[i] <= '0;
        rem_q[i]   <= '0;
      end
    end else if (clr) begin
      sp_q <= '0;
      for (int unsigned i = 0; i < LOOP_DEPTH; i++) begin
        start_q[i] <= '0;
        rem_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < LOOP_DEPTH; i++) begin
        if (push && !full && (SP_W'(i) == sp_q)) begin
          start_q[i] <= push_start;
          rem_q[i]   <= push_cnt;
        end
        if (dec && !empty && (SP_W'(i) == top_idx)) begin
          rem_q[i] <= rem_q[i] - CNT_W'(1);
        end
      end
      if (push && !full) begin
        sp_q <= sp_q + SP_W'(1);
      end else if (pop && !empty) begin
        sp_q <= sp_q - SP_W'(1);
      end
    end
  end

  always_comb begin
    top_start     = '0;
    top_remaining = '0;
    for (int unsigned i = 0; i < LOOP_DEPTH; i++) begin
      if (!empty && (SP_W'(i) == top_idx)) begin
        top_start     = start_q[i];
        top_remaining = rem_q[i];
      end
    end
  end

endmodule

// File: rtl/useq_sequencer.sv
// Micro-program sequencer: fetches from a synchronous micro-ROM one word per
// cycle, with nested zero-overhead hardware loops, done/abort/fault handling.
module useq_sequencer
  import useq_pkg::*;
#(
  parameter int unsigned UPC_W      = 8,
  parameter int unsigned UINST_W    = 32,
  parameter int unsigned LOOP_DEPTH = 3,
  parameter int unsigned CNT_W      = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [UPC_W-1:0]            cmd_upc,
  input  logic [LOOP_DEPTH*CNT_W-1:0] cmd_loops,
  input  logic                        abort,
  output logic [UPC_W-1:0]            urom_addr,
  input  logic [UINST_W-1:0]          urom_data,
  output logic [UINST_W-4:0]          ctrl_out,
  output logic                        ctrl_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned SP_W = sp_width(LOOP_DEPTH);

  useq_state_e state_q, state_d;

  logic [UPC_W-1:0]            upc_q, upc_d, upc_inc;
  logic                        upc_wrap;
  logic [LOOP_DEPTH*CNT_W-1:0] loops_q;
  logic                        done_q, err_q, done_set, err_set;
  logic                        u_done, u_push, u_end;
  logic                        accept;
  logic                        st_push, st_pop, st_dec, st_clr;
  logic [UPC_W-1:0]            top_start;
  logic [CNT_W-1:0]            top_rem, lvl_cnt, push_cnt;
  logic [SP_W-1:0]             sp;
  logic                        st_full, st_empty;

  assign u_done   = urom_data[DONE_BIT];
  assign u_push   = urom_data[PUSH_BIT];
  assign u_end    = urom_data[END_BIT];
  assign accept   = cmd_valid && (state_q == IDLE) && !abort;
  assign upc_inc  = upc_q + UPC_W'(1);
  assign upc_wrap = (upc_q == '1);

  // Iteration count for the level about to be opened; zero runs the body once.
  always_comb begin
    lvl_cnt = '0;
    for (int unsigned i = 0; i < LOOP_DEPTH; i++) begin
      if (SP_W'(i) == sp) begin
        lvl_cnt = loops_q[i*CNT_W +: CNT_W];
      end
    end
    push_cnt = (lvl_cnt == '0) ? CNT_W'(1) : lvl_cnt;
  end

  useq_loop_stack #(
    .LOOP_DEPTH (LOOP_DEPTH),
    .UPC_W      (UPC_W),
    .CNT_W      (CNT_W)
  ) u_stack (
    .clk           (clk),
    .rst           (rst),
    .push          (st_push),
    .pop           (st_pop),
    .dec           (st_dec),
    .clr           (st_clr),
    .push_start    (upc_inc),
    .push_cnt      (push_cnt),
    .top_start     (top_start),
    .top_remaining (top_rem),
    .sp            (sp),
    .full          (st_full),
    .empty         (st_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority in EXEC: abort, done, then loop-bit decode; every exit clears the stack.
  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    st_push  = 1'b0;
    st_pop   = 1'b0;
    st_dec   = 1'b0;
    st_clr   = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          upc_d   = cmd_upc;
        end
      end
      EXEC: begin
        upc_d = upc_inc;
        if (abort) begin
          state_d = IDLE;
          st_clr  = 1'b1;
        end else if (u_done) begin
          state_d  = IDLE;
          st_clr   = 1'b1;
          done_set = 1'b1;
        end else if (u_push && u_end) begin
          state_d = IDLE;
          st_clr  = 1'b1;
          err_set = 1'b1;
        end else if (u_push) begin
          if (st_full || upc_wrap) begin
            state_d = IDLE;
            st_clr  = 1'b1;
            err_set = 1'b1;
          end else begin
            st_push = 1'b1;
          end
        end else if (u_end) begin
          if (st_empty) begin
            state_d = IDLE;
            st_clr  = 1'b1;
            err_set = 1'b1;
          end else if (top_rem > CNT_W'(1)) begin
            st_dec = 1'b1;
            upc_d  = top_start;
          end else if (upc_wrap) begin
            state_d = IDLE;
            st_clr  = 1'b1;
            err_set = 1'b1;
          end else begin
            st_pop = 1'b1;
          end
        end else if (upc_wrap) begin
          state_d = IDLE;
          st_clr  = 1'b1;
          err_set = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        st_clr  = 1'b1;
      end
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == IDLE) && !abort;
    busy       = (state_q == EXEC);
    ctrl_valid = (state_q == EXEC);
    ctrl_out   = ctrl_valid ? urom_data[UINST_W-1:CTRL_LSB] : '0;
    urom_addr  = (state_q == IDLE) ? cmd_upc : upc_d;
    done       = done_q;
    err        = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upc_q   <= '0;
      loops_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      upc_q  <= upc_d;
      done_q <= done_set;
      err_q  <= err_set;
      if (accept) begin
        loops_q <= cmd_loops;
      end
    end
  end

endmodule

// File: tb/tb_useq_sequencer.sv
// Scoreboard bench for useq_sequencer: directed micro-programs, expected
// per-cycle output traces queued at command accept, checked by monitors.
module tb_useq_sequencer;

  typedef struct packed {
    logic        valid;
    logic [28:0] ctrl;
    logic        done;
    logic        err;
    logic        busy;
    logic        ready;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cmd_upc = '0;

  logic        cmd_valid = 1'b0, cmd_ready;
  logic [32:0] cmd_loops = '0;
  logic [7:0]  urom_addr;
  logic [31:0] urom_data = '0;
  logic [28:0] ctrl_out;
  logic        ctrl_valid, busy, done, err;

  logic        cmd_valid1 = 1'b0, cmd_ready1;
  logic [10:0] cmd_loops1 = '0;
  logic [7:0]  urom_addr1;
  logic [31:0] urom_data1 = '0;
  logic [28:0] ctrl_out1;
  logic        ctrl_valid1, busy1, done1, err1;

  logic [31:0] rom [256];
  item_t       exp_q[$];
  item_t       exp1_q[$];
  int unsigned trace_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  useq_sequencer #(.UPC_W(8), .UINST_W(32), .LOOP_DEPTH(3), .CNT_W(11)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_upc(cmd_upc), .cmd_loops(cmd_loops), .abort(abort),
    .urom_addr(urom_addr), .urom_data(urom_data), .ctrl_out(ctrl_out),
    .ctrl_valid(ctrl_valid), .busy(busy), .done(done), .err(err)
  );

  useq_sequencer #(.UPC_W(8), .UINST_W(32), .LOOP_DEPTH(1), .CNT_W(11)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_upc(cmd_upc), .cmd_loops(cmd_loops1), .abort(abort),
    .urom_addr(urom_addr1), .urom_data(urom_data1), .ctrl_out(ctrl_out1),
    .ctrl_valid(ctrl_valid1), .busy(busy1), .done(done1), .err(err1)
  );

  always @(posedge clk) begin
    urom_data  <= rom[urom_addr];
    urom_data1 <= rom[urom_addr1];
  end

  function automatic logic [28:0] ctrl_of(input logic [7:0] a);
    return 29'h0A50000 | {21'd0, a};
  endfunction

  task automatic rom_w(input logic [7:0] a, input logic [2:0] f);
    rom[a] = {ctrl_of(a), f};
  endtask

  task automatic chk_item(input string nm, input item_t e, input item_t a);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got v=%0b ctrl=%h done=%0b err=%0b busy=%0b rdy=%0b expected v=%0b ctrl=%h done=%0b err=%0b busy=%0b rdy=%0b",
               nm, $time, a.valid, a.ctrl, a.done, a.err, a.busy, a.ready,
               e.valid, e.ctrl, e.done, e.err, e.busy, e.ready);
    end
  endtask

  task automatic chk1(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, want);
    end
  endtask

  function automatic item_t quiet_item();
    item_t q;
    q = '0;
    q.ready = !abort;
    return q;
  endfunction

  always @(negedge clk) begin
    item_t a, e;
    a.valid = ctrl_valid; a.ctrl = ctrl_out; a.done = done;
    a.err = err; a.busy = busy; a.ready = cmd_ready;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : quiet_item();
    chk_item("dut_cycle", e, a);
  end

  always @(negedge clk) begin
    item_t a, e;
    a.valid = ctrl_valid1; a.ctrl = ctrl_out1; a.done = done1;
    a.err = err1; a.busy = busy1; a.ready = cmd_ready1;
    e = (exp1_q.size() > 0) ? exp1_q.pop_front() : quiet_item();
    chk_item("dut1_cycle", e, a);
  end

  // end_kind: 0 none, 1 done pulse, 2 err pulse
  task automatic load_exp(input int sel, input int end_kind);
    item_t it;
    foreach (trace_q[i]) begin
      it = '0;
      it.valid = 1'b1;
      it.ctrl  = ctrl_of(8'(trace_q[i]));
      it.busy  = 1'b1;
      if (sel == 0) exp_q.push_back(it); else exp1_q.push_back(it);
    end
    if (end_kind != 0) begin
      it = '0;
      it.done  = (end_kind == 1);
      it.err   = (end_kind == 2);
      it.ready = 1'b1;
      if (sel == 0) exp_q.push_back(it); else exp1_q.push_back(it);
    end
  endtask

  task automatic send_cmd(input int sel, input logic [7:0] upc,
                          input logic [32:0] loops, input int end_kind);
    int n;
    n = 0;
    cmd_upc = upc;
    if (sel == 0) begin cmd_loops = loops; cmd_valid = 1'b1; end
    else begin cmd_loops1 = loops[10:0]; cmd_valid1 = 1'b1; end
    while (!((sel == 0) ? cmd_ready : cmd_ready1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL cmd_accept got ready=0 expected ready=1 within 100 cycles");
      cmd_valid = 1'b0; cmd_valid1 = 1'b0;
      return;
    end
    @(posedge clk);
    load_exp(sel, end_kind);
    #1;
    cmd_valid = 1'b0; cmd_valid1 = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain got %0d/%0d pending expected 0", exp_q.size(), exp1_q.size());
      exp_q.delete(); exp1_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = {ctrl_of(8'(a)), 3'b000};
    rom_w(8'h13, 3'b001);
    rom_w(8'h20, 3'b010); rom_w(8'h22, 3'b100); rom_w(8'h23, 3'b001);
    rom_w(8'h30, 3'b010); rom_w(8'h31, 3'b010); rom_w(8'h33, 3'b100);
    rom_w(8'h34, 3'b100); rom_w(8'h35, 3'b001);
    rom_w(8'h40, 3'b010); rom_w(8'h43, 3'b100); rom_w(8'h44, 3'b001);
    rom_w(8'h51, 3'b100);
    rom_w(8'h60, 3'b010); rom_w(8'h61, 3'b100); rom_w(8'h62, 3'b001);
    rom_w(8'h70, 3'b110);
    rom_w(8'h78, 3'b111);

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk1("reset_ready", {31'd0, cmd_ready}, 32'd1);
    chk1("reset_ready1", {31'd0, cmd_ready1}, 32'd1);
    chk1("reset_busy", {31'd0, busy}, 32'd0);

    // straight-line program, then a back-to-back command in the done cycle
    trace_q = '{32'h10, 32'h11, 32'h12, 32'h13};
    send_cmd(0, 8'h10, 33'd0, 1);
    send_cmd(0, 8'h10, 33'd0, 1);
    wait_drain();

    // single loop, count 3
    trace_q = '{32'h20, 32'h21, 32'h22, 32'h21, 32'h22, 32'h21, 32'h22, 32'h23};
    send_cmd(0, 8'h20, {11'd0, 11'd0, 11'd3}, 1);
    wait_drain();

    // nested loops: outer 2, inner 3
    trace_q = '{32'h30, 32'h31, 32'h32, 32'h33, 32'h32, 32'h33, 32'h32, 32'h33, 32'h34,
                32'h31, 32'h32, 32'h33, 32'h32, 32'h33, 32'h32, 32'h33, 32'h34, 32'h35};
    send_cmd(0, 8'h30, {11'd5, 11'd3, 11'd2}, 1);
    wait_drain();

    // depth-1 build overflows on the second push
    trace_q = '{32'h30, 32'h31};
    send_cmd(1, 8'h30, 33'd2, 2);
    wait_drain();

    // abort on 3rd EXEC cycle with one loop level open
    trace_q = '{32'h40, 32'h41, 32'h42};
    send_cmd(0, 8'h40, {11'd5, 11'd3, 11'd2}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(posedge clk); #1;
    // abort in IDLE blocks acceptance
    abort = 1'b1; cmd_upc = 8'h10; cmd_valid = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; cmd_valid = 1'b0;
    @(posedge clk); #1;

    // stack must be empty: the nested program must use levels 0 and 1
    trace_q = '{32'h30, 32'h31, 32'h32, 32'h33, 32'h32, 32'h33, 32'h32, 32'h33, 32'h34,
                32'h31, 32'h32, 32'h33, 32'h32, 32'h33, 32'h32, 32'h33, 32'h34, 32'h35};
    send_cmd(0, 8'h30, {11'd5, 11'd3, 11'd2}, 1);
    wait_drain();

    // loop_end with empty stack
    trace_q = '{32'h50, 32'h51};
    send_cmd(0, 8'h50, 33'd0, 2);
    wait_drain();

    // sequential increment wrapping past 0xFF
    trace_q = '{32'hFE, 32'hFF};
    send_cmd(0, 8'hFE, 33'd0, 2);
    wait_drain();

    // count 0 runs the body once
    trace_q = '{32'h60, 32'h61, 32'h62};
    send_cmd(0, 8'h60, 33'd0, 1);
    wait_drain();

    // push and end in one uinst
    trace_q = '{32'h70};
    send_cmd(0, 8'h70, 33'd3, 2);
    wait_drain();

    // done wins over loop bits
    trace_q = '{32'h78};
    send_cmd(0, 8'h78, 33'd3, 1);
    wait_drain();

    // reset mid-loop
    trace_q = '{32'h20, 32'h21, 32'h22};
    send_cmd(0, 8'h20, {11'd0, 11'd0, 11'd3}, 0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk1("rst_ctrl_valid", {31'd0, ctrl_valid}, 32'd0);
    chk1("rst_ctrl_out", {3'd0, ctrl_out}, 32'd0);
    chk1("rst_busy", {31'd0, busy}, 32'd0);
    chk1("rst_done", {31'd0, done}, 32'd0);
    chk1("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("rst_release_ready", {31'd0, cmd_ready}, 32'd1);
    trace_q = '{32'h20, 32'h21, 32'h22, 32'h21, 32'h22, 32'h21, 32'h22, 32'h23};
    send_cmd(0, 8'h20, {11'd0, 11'd0, 11'd3}, 1);
    wait_drain();

    chk1("queue_empty", exp_q.size() + exp1_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
